// File: rtl/ipv4_encap.sv
// IPv4 encapsulation: buffers one UDP datagram, then emits a 20-byte IPv4 header plus payload.
// Optional IPV4_ENCAP_STATS_EN adds saturating tx_count/drop_count outputs.
module ipv4_encap #(
  parameter logic [31:0] SRC_IP  = 32'hC0A8010A,
  parameter logic [31:0] DST_IP  = 32'hC0A80114,
  parameter logic [7:0]  TTL     = 8'd64,
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  udp_data,
  input  logic        udp_valid,
  output logic [7:0]  ip_data,
  output logic        ip_valid,
  output logic        ip_last,
  input  logic        ip_ready,
`ifdef IPV4_ENCAP_STATS_EN
  output logic [15:0] tx_count,
  output logic [15:0] drop_count,
`endif
  output logic        busy,
  output logic        drop
);

  typedef logic [ADDR_W:0] cnt_t;
  typedef enum logic [2:0] {StIdle, StCapture, StCsum, StHdr, StPayload} state_e;

  localparam cnt_t MaxCnt   = cnt_t'(MAX_LEN);
  localparam cnt_t MinCnt   = cnt_t'(8);
  localparam cnt_t CsumLast = cnt_t'(9);
  localparam cnt_t HdrLast  = cnt_t'(19);

  state_e      state_q;
  cnt_t        count_q;
  cnt_t        idx_q;
  logic        ovf_q;
  logic        ign_q;
  logic [15:0] acc_q;
  logic [15:0] ident_q;
  logic [7:0]  buffer_q [MAX_LEN];

  logic        buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [15:0] tot_len;
  logic [15:0] csum_word;
  logic [16:0] csum_sum;
  logic [15:0] csum_fold;
  logic [15:0] ck;
  logic [7:0]  hdr_byte;

  assign busy     = (state_q != StIdle);
  assign tot_len  = 16'(count_q) + 16'd20;
  assign ck       = ~acc_q;
  assign csum_sum = {1'b0, acc_q} + {1'b0, csum_word};
  // End-around carry keeps the running sum in ones' complement form.
  assign csum_fold = csum_sum[15:0] + {15'b0, csum_sum[16]};

  assign buf_we   = ((state_q == StIdle) && udp_valid && !ign_q) ||
                    ((state_q == StCapture) && udp_valid && (count_q != MaxCnt));
  assign buf_addr = (state_q == StIdle) ? '0 : count_q[ADDR_W-1:0];

  always_comb begin
    csum_word = 16'h0000;
    case (idx_q[3:0])
      4'd0:    csum_word = 16'h4500;
      4'd1:    csum_word = tot_len;
      4'd2:    csum_word = ident_q;
      4'd3:    csum_word = 16'h4000;
      4'd4:    csum_word = {TTL, 8'h11};
      4'd6:    csum_word = SRC_IP[31:16];
      4'd7:    csum_word = SRC_IP[15:0];
      4'd8:    csum_word = DST_IP[31:16];
      4'd9:    csum_word = DST_IP[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q[4:0])
      5'd0:    hdr_byte = 8'h45;
      5'd2:    hdr_byte = tot_len[15:8];
      5'd3:    hdr_byte = tot_len[7:0];
      5'd4:    hdr_byte = ident_q[15:8];
      5'd5:    hdr_byte = ident_q[7:0];
      5'd6:    hdr_byte = 8'h40;
      5'd8:    hdr_byte = TTL;
      5'd9:    hdr_byte = 8'h11;
      5'd10:   hdr_byte = ck[15:8];
      5'd11:   hdr_byte = ck[7:0];
      5'd12:   hdr_byte = SRC_IP[31:24];
      5'd13:   hdr_byte = SRC_IP[23:16];
      5'd14:   hdr_byte = SRC_IP[15:8];
      5'd15:   hdr_byte = SRC_IP[7:0];
      5'd16:   hdr_byte = DST_IP[31:24];
      5'd17:   hdr_byte = DST_IP[23:16];
      5'd18:   hdr_byte = DST_IP[15:8];
      5'd19:   hdr_byte = DST_IP[7:0];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_we) buffer_q[buf_addr] <= udp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      ign_q    <= 1'b0;
      acc_q    <= 16'h0000;
      ident_q  <= 16'h0000;
      ip_data  <= 8'h00;
      ip_valid <= 1'b0;
      ip_last  <= 1'b0;
      drop     <= 1'b0;
    end else begin
      drop <= 1'b0;
      // A datagram arriving while a packet is in flight is tracked independently of the FSM.
      if (ign_q && !udp_valid) begin
        ign_q <= 1'b0;
        drop  <= 1'b1;
      end else if (udp_valid && (state_q inside {StCsum, StHdr, StPayload})) begin
        ign_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (udp_valid && !ign_q) begin
            count_q <= cnt_t'(1);
            ovf_q   <= 1'b0;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (udp_valid) begin
            if (count_q == MaxCnt) ovf_q <= 1'b1;
            else count_q <= count_q + cnt_t'(1);
          end else if (ovf_q || (count_q < MinCnt)) begin
            drop    <= 1'b1;
            state_q <= StIdle;
          end else begin
            idx_q   <= '0;
            acc_q   <= 16'h0000;
            state_q <= StCsum;
          end
        end
        StCsum: begin
          acc_q <= csum_fold;
          if (idx_q == CsumLast) begin
            idx_q   <= '0;
            state_q <= StHdr;
          end else begin
            idx_q <= idx_q + cnt_t'(1);
          end
        end
        StHdr: begin
          if (!ip_valid || ip_ready) begin
            ip_data  <= hdr_byte;
            ip_valid <= 1'b1;
            if (idx_q == HdrLast) begin
              idx_q   <= '0;
              state_q <= StPayload;
            end else begin
              idx_q <= idx_q + cnt_t'(1);
            end
          end
        end
        StPayload: begin
          if (ip_valid && ip_ready && ip_last) begin
            ip_valid <= 1'b0;
            ip_last  <= 1'b0;
            ident_q  <= ident_q + 16'd1;
            state_q  <= StIdle;
          end else if (!ip_valid || ip_ready) begin
            ip_data  <= buffer_q[idx_q[ADDR_W-1:0]];
            ip_valid <= 1'b1;
            ip_last  <= (idx_q == (count_q - cnt_t'(1)));
            idx_q    <= idx_q + cnt_t'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef IPV4_ENCAP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count   <= 16'h0000;
      drop_count <= 16'h0000;
    end else begin
      if ((state_q == StPayload) && ip_valid && ip_ready && ip_last && (tx_count != 16'hFFFF))
        tx_count <= tx_count + 16'd1;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ipv4_encap.sv
// Self-checking bench for ipv4_encap: vector table plus scoreboard of expected output bytes.
module tb_ipv4_encap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  udp_data;
  logic        udp_valid;
  logic [7:0]  ip_data;
  logic        ip_valid;
  logic        ip_last;
  logic        ip_ready;
  logic        busy;
  logic        drop;
`ifdef IPV4_ENCAP_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] drop_count;
`endif

  ipv4_encap dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .udp_data  (udp_data),
    .udp_valid (udp_valid),
    .ip_data   (ip_data),
    .ip_valid  (ip_valid),
    .ip_last   (ip_last),
    .ip_ready  (ip_ready),
`ifdef IPV4_ENCAP_STATS_EN
    .tx_count  (tx_count),
    .drop_count(drop_count),
`endif
    .busy      (busy),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          rdy;       // 0 always ready, 1 toggle, 2 random
    bit          exp_drop;
    logic [15:0] exp_ck;    // 0 means not checked
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  sbq[$];
  logic [7:0]  pay[0:79];
  logic [7:0]  hello[0:18];
  int          rdy_mode = 0;
  logic [15:0] ident_m = 16'h0000;
  int          drops_seen = 0;
  int          tx_seen = 0;
  int          popped = 0;
  logic [7:0]  cur_pkt[0:127];
  logic [7:0]  last_pkt[0:127];
  int          cur_len = 0;
  int          last_len = 0;
  bit          hold_q = 1'b0;
  logic [8:0]  hold_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_pkt(input int len);
    logic [15:0] w[10];
    logic [31:0] sum;
    logic [15:0] tl;
    logic [15:0] ckv;
    logic [7:0]  h[20];
    tl = 16'(20 + len);
    w = '{16'h4500, tl, ident_m, 16'h4000, 16'h4011, 16'h0000,
          16'hC0A8, 16'h010A, 16'hC0A8, 16'h0114};
    sum = 0;
    for (int k = 0; k < 10; k++) sum += 32'(w[k]);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = (sum & 32'hFFFF) + (sum >> 16);
    ckv = ~sum[15:0];
    h = '{8'h45, 8'h00, tl[15:8], tl[7:0], ident_m[15:8], ident_m[7:0], 8'h40, 8'h00,
          8'h40, 8'h11, ckv[15:8], ckv[7:0], 8'hC0, 8'hA8, 8'h01, 8'h0A,
          8'hC0, 8'hA8, 8'h01, 8'h14};
    for (int k = 0; k < 20; k++) sbq.push_back({1'b0, h[k]});
    for (int k = 0; k < len; k++) sbq.push_back({(k == len - 1), pay[k]});
    ident_m++;
  endfunction

  task automatic send(input int len, input bit expect_pkt);
    if (expect_pkt) push_pkt(len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      udp_valid = 1'b1;
      udp_data  = pay[k];
    end
    @(posedge clk); #1;
    udp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sbq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n >= 3000), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  // Ready generator
  initial begin
    ip_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       ip_ready = 1'b1;
        1:       ip_ready = ~ip_ready;
        default: ip_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q  = 1'b0;
        cur_len = 0;
      end else begin
        if (drop) drops_seen++;
        if (hold_q) chk("hold", {ip_valid, ip_last, ip_data}, {1'b1, hold_v});
        if (ip_valid && ip_ready) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none (t=%0t)", ip_data, $time);
          end else begin
            e = sbq.pop_front();
            chk("byte", {ip_last, ip_data}, e);
          end
          popped++;
          if (cur_len < 128) cur_pkt[cur_len] = ip_data;
          cur_len++;
          if (ip_last) begin
            last_pkt = cur_pkt;
            last_len = cur_len;
            cur_len  = 0;
            tx_seen++;
          end
        end
        hold_q = ip_valid && !ip_ready;
        hold_v = {ip_last, ip_data};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   d0, t0, p0, n;

    vecs[0] = '{19, 0, 1'b0, 16'hB757};
    vecs[1] = '{19, 0, 1'b0, 16'hB756};
    vecs[2] = '{19, 1, 1'b0, 16'hB755};
    vecs[3] = '{5,  0, 1'b1, 16'h0000};
    vecs[4] = '{70, 0, 1'b1, 16'h0000};
    vecs[5] = '{19, 0, 1'b0, 16'hB754};
    vecs[6] = '{7,  0, 1'b1, 16'h0000};
    vecs[7] = '{8,  2, 1'b0, 16'h0000};
    vecs[8] = '{64, 2, 1'b0, 16'h0000};
    vecs[9] = '{65, 0, 1'b1, 16'h0000};
    hello = '{8'h13, 8'h88, 8'h13, 8'h89, 8'h00, 8'h13, 8'h00, 8'h00,
              8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    udp_valid = 1'b0;
    udp_data  = 8'h00;

    #1;
    chk("rst_ip_valid", 32'(ip_valid), 0);
    chk("rst_ip_last",  32'(ip_last), 0);
    chk("rst_ip_data",  32'(ip_data), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_drop",     32'(drop), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rdy_mode = vecs[i].rdy;
      for (int k = 0; k < 80; k++) pay[k] = (vecs[i].len == 19 && k < 19) ? hello[k]
                                                                         : 8'($urandom);
      d0 = drops_seen;
      t0 = tx_seen;
      send(vecs[i].len, !vecs[i].exp_drop);
      if (i == 0) begin
        n = 0;
        while (n < 30) begin
          @(posedge clk); #2;
          if (ip_valid) break;
          n++;
        end
        chk("first_byte_latency", 32'(n), 32'd11);
      end
      wait_idle("vec");
      chk("vec_drops", 32'(drops_seen - d0), 32'(vecs[i].exp_drop));
      chk("vec_tx", 32'(tx_seen - t0), 32'(!vecs[i].exp_drop));
      if (!vecs[i].exp_drop) chk("vec_len", 32'(last_len), 32'(vecs[i].len + 20));
      if (vecs[i].exp_ck != 16'h0000) chk("vec_ck", {last_pkt[10], last_pkt[11]}, vecs[i].exp_ck);
      rdy_mode = 0;
    end

    // Second datagram arriving during header emission
    for (int k = 0; k < 19; k++) pay[k] = hello[k];
    d0 = drops_seen;
    t0 = tx_seen;
    send(19, 1'b1);
    n = 0;
    while (!ip_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_hdr_seen", 32'(ip_valid), 32'd1);
    for (int k = 0; k < 80; k++) pay[k] = 8'($urandom);
    send(10, 1'b0);
    wait_idle("t5");
    chk("t5_drops", 32'(drops_seen - d0), 32'd1);
    chk("t5_tx", 32'(tx_seen - t0), 32'd1);
    for (int k = 0; k < 19; k++) pay[k] = hello[k];
    send(19, 1'b1);
    wait_idle("t5_next");
    chk("t5_next_id", {last_pkt[4], last_pkt[5]}, 32'(ident_m - 16'd1));

    // Reset during payload byte 5
    p0 = popped;
    send(19, 1'b1);
    n = 0;
    while (popped < p0 + 25 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t6_reach_payload", 32'(popped >= p0 + 25), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ip_valid", 32'(ip_valid), 0);
    chk("t6_ip_last", 32'(ip_last), 0);
    chk("t6_busy", 32'(busy), 0);
    sbq.delete();
    ident_m  = 16'h0000;
    tx_seen  = 0;
    drops_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send(19, 1'b1);
    wait_idle("t6_after");
    chk("t6_len", 32'(last_len), 32'd39);
    chk("t6_id", {last_pkt[4], last_pkt[5]}, 32'h0000);
    chk("t6_ck", {last_pkt[10], last_pkt[11]}, 32'hB757);
`ifdef IPV4_ENCAP_STATS_EN
    chk("tx_count", 32'(tx_count), 32'(tx_seen));
    chk("drop_count", 32'(drop_count), 32'(drops_seen));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
